// File: rtl/ysyx_25050147_mem_arbiter_pkg.sv
// Shared types and defaults for the IFU/LSU data-memory arbiter.
// Included by the interface, the watchdog counter and the arbiter top.
package ysyx_25050147_mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TO_CYC = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/ysyx_25050147_mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around the arbiter.
// slave is the arbiter's view; master is the view of the IFU/LSU/memory environment.
interface ysyx_25050147_mem_arbiter_if
    import ysyx_25050147_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;
    logic              ifu_resp_err;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [7:0]        lsu_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;
    logic              lsu_resp_err;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [7:0]        mem_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/ysyx_25050147_mem_arbiter_wdt_cnt.sv
// 8-bit saturating response watchdog: cleared outside WAIT, counts while waiting,
// and flags expiry once TO_CYC cycles have been spent in WAIT.
module ysyx_25050147_mem_arbiter_wdt_cnt
    import ysyx_25050147_mem_arbiter_pkg::*;
#(
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (en && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    // The first WAIT cycle sees cnt==0, so this fires on the TO_CYC-th cycle.
    assign expire = (cnt == 8'(TO_CYC - 1));

endmodule

// File: rtl/ysyx_25050147_mem_arbiter.sv
// Fixed-priority (LSU over IFU) single-outstanding arbiter for the data-memory port,
// with a watchdog that turns a hung access into an error response.
module ysyx_25050147_mem_arbiter
    import ysyx_25050147_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic                         clk,
    input  logic                         rst,
    ysyx_25050147_mem_arbiter_if.slave   bus,
    output logic                         busy
);

    state_t            state;
    state_t            state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;

    logic              lsu_grant;
    logic              ifu_grant;
    logic              resp_fire;
    logic              resp_err;
    logic [DATA_W-1:0] resp_data;
    logic              expire;

    ysyx_25050147_mem_arbiter_wdt_cnt #(
        .TO_CYC (TO_CYC)
    ) u_wdt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state != ST_WAIT),
        .en     (state == ST_WAIT),
        .expire (expire)
    );

    // Grants are gated by reset so the request side stays quiet while rst is low.
    always_comb begin
        state_nxt = state;
        lsu_grant = 1'b0;
        ifu_grant = 1'b0;
        resp_fire = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        case (state)
            ST_IDLE: begin
                lsu_grant = rst && bus.lsu_req_valid;
                ifu_grant = rst && bus.ifu_req_valid && !bus.lsu_req_valid;
                if (lsu_grant || ifu_grant) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_fire = 1'b1;
                    resp_data = wen_q ? '0 : bus.mem_resp_data;
                    state_nxt = ST_IDLE;
                end else if (expire) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (lsu_grant) begin
                owner   <= OWN_LSU;
                addr_q  <= bus.lsu_addr;
                wen_q   <= bus.lsu_wen;
                wdata_q <= bus.lsu_wdata;
                wmask_q <= bus.lsu_wmask;
            end else if (ifu_grant) begin
                owner   <= OWN_IFU;
                addr_q  <= bus.ifu_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= 8'h00;
            end
        end
    end

    assign bus.ifu_req_ready  = ifu_grant;
    assign bus.lsu_req_ready  = lsu_grant;

    assign bus.mem_req_valid  = (state == ST_REQ);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;

    assign bus.ifu_resp_valid = resp_fire && (owner == OWN_IFU);
    assign bus.ifu_resp_data  = (owner == OWN_IFU) ? resp_data : '0;
    assign bus.ifu_resp_err   = resp_err && (owner == OWN_IFU);
    assign bus.lsu_resp_valid = resp_fire && (owner == OWN_LSU);
    assign bus.lsu_resp_data  = (owner == OWN_LSU) ? resp_data : '0;
    assign bus.lsu_resp_err   = resp_err && (owner == OWN_LSU);

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_25050147_mem_arbiter.sv
// Testbench for the IFU/LSU memory arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_ysyx_25050147_mem_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_25050147_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_25050147_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TO_CYC (TO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    logic [144:0] all_out;
    assign all_out = {busy, bus.ifu_req_ready, bus.ifu_resp_valid, bus.ifu_resp_data,
                      bus.ifu_resp_err, bus.lsu_req_ready, bus.lsu_resp_valid,
                      bus.lsu_resp_data, bus.lsu_resp_err, bus.mem_req_valid,
                      bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = 8'h00;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    // One complete transaction; expected behaviour follows from the arbitration rules:
    // LSU wins, request held until ready, response at WAIT cycle min(respd+1, TO).
    task automatic do_txn(input logic iv, input logic lv, input logic [31:0] ia,
                          input logic [31:0] la, input logic lw, input logic [31:0] ld,
                          input logic [7:0] lm, input int rd, input int respd,
                          input logic stray, input logic fixd, input logic [31:0] fdata);
        logic [31:0] ea;
        logic        ew;
        logic [7:0]  em;
        logic        eerr;
        int          re;
        logic [31:0] md;
        logic [31:0] edata;
        ea   = lv ? la : ia;
        ew   = lv ? lw : 1'b0;
        em   = lv ? lm : 8'h00;
        eerr = (respd + 1 > TO);
        re   = eerr ? TO : respd + 1;

        bus.ifu_req_valid = iv;
        bus.ifu_addr      = ia;
        bus.lsu_req_valid = lv;
        bus.lsu_addr      = la;
        bus.lsu_wen       = lw;
        bus.lsu_wdata     = ld;
        bus.lsu_wmask     = lm;
        @(negedge clk);
        checks++;
        if ({bus.lsu_req_ready, bus.ifu_req_ready} !== {lv, iv && !lv}) begin
            errors++;
            $display("[TB] FAIL grant: got lsu/ifu ready=%b expected %b",
                     {bus.lsu_req_ready, bus.ifu_req_ready}, {lv, iv && !lv});
        end
        tick();

        for (int k = 0; k <= rd; k++) begin
            bus.ifu_req_valid = 1'($urandom_range(0, 1));
            bus.lsu_req_valid = 1'($urandom_range(0, 1));
            bus.ifu_addr      = $urandom;
            bus.lsu_addr      = $urandom;
            bus.lsu_wdata     = $urandom;
            bus.lsu_wmask     = 8'($urandom);
            bus.mem_req_ready = (k == rd);
            @(negedge clk);
            checks++;
            if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask} !== {1'b1, ea, ew, em}) begin
                errors++;
                $display("[TB] FAIL mem_req: got v=%b a=%h w=%b m=%h expected v=1 a=%h w=%b m=%h",
                         bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask, ea, ew, em);
            end
            if (lv) begin
                checks++;
                if (bus.mem_wdata !== ld) begin
                    errors++;
                    $display("[TB] FAIL mem_wdata: got %h expected %h", bus.mem_wdata, ld);
                end
            end
            checks++;
            if ({busy, bus.ifu_req_ready, bus.lsu_req_ready} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL req_busy: got busy/ifu_rdy/lsu_rdy=%b expected 100",
                         {busy, bus.ifu_req_ready, bus.lsu_req_ready});
            end
            tick();
        end
        bus.mem_req_ready = 1'b0;

        for (int w = 1; w <= re; w++) begin
            md = fixd ? fdata : $urandom;
            bus.mem_resp_data  = md;
            bus.mem_resp_valid = (w == respd + 1);
            bus.ifu_req_valid  = (w == re) ? 1'b0 : 1'($urandom_range(0, 1));
            bus.lsu_req_valid  = (w == re) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (w < re) begin
                checks++;
                if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid,
                     bus.ifu_req_ready, bus.lsu_req_ready} !== 5'b0) begin
                    errors++;
                    $display("[TB] FAIL wait_quiet: got ifu_rv/lsu_rv/mreq/ifu_rdy/lsu_rdy=%b expected 00000 at wait cycle %0d",
                             {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid,
                              bus.ifu_req_ready, bus.lsu_req_ready}, w);
                end
            end else begin
                edata = (eerr || ew) ? 32'h0 : md;
                checks++;
                if ({bus.lsu_resp_valid, bus.ifu_resp_valid} !== {lv, !lv}) begin
                    errors++;
                    $display("[TB] FAIL resp_owner: got lsu/ifu resp_valid=%b expected %b at wait cycle %0d",
                             {bus.lsu_resp_valid, bus.ifu_resp_valid}, {lv, !lv}, w);
                end
                checks++;
                if (lv ? ({bus.lsu_resp_data, bus.lsu_resp_err} !== {edata, eerr})
                       : ({bus.ifu_resp_data, bus.ifu_resp_err} !== {edata, eerr})) begin
                    errors++;
                    $display("[TB] FAIL resp_data: got lsu=%h/%b ifu=%h/%b expected data=%h err=%b",
                             bus.lsu_resp_data, bus.lsu_resp_err, bus.ifu_resp_data,
                             bus.ifu_resp_err, edata, eerr);
                end
            end
            tick();
        end

        bus.mem_resp_valid = stray;
        bus.mem_resp_data  = $urandom;
        @(negedge clk);
        checks++;
        if ({busy, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_after: got busy/ifu_rv/lsu_rv=%b expected 000 (stray=%b)",
                     {busy, bus.ifu_resp_valid, bus.lsu_resp_valid}, stray);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.ifu_req_valid  = 1'b1;
        bus.lsu_req_valid  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_held: got %h expected 0", all_out);
        end
        clear_inputs();
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_0010;
        bus.lsu_wen       = 1'b0;
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_wait_busy: got %b expected 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait: got %h expected 0", all_out);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if ({busy, bus.lsu_resp_valid, bus.ifu_resp_valid} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL late_resp_after_reset: got busy/lsu_rv/ifu_rv=%b expected 000",
                     {busy, bus.lsu_resp_valid, bus.ifu_resp_valid});
        end
        tick();
        bus.mem_resp_valid = 1'b0;
    endtask

    task automatic test_ifu_basic();
        do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 8'h00,
               0, 0, 1'b0, 1'b1, 32'h0010_0073);
    endtask

    task automatic test_back_to_back();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0004;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_1000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 32'hDEAD_BEEF;
        bus.lsu_wmask     = 8'h0F;
        @(negedge clk);
        checks++;
        if ({bus.lsu_req_ready, bus.ifu_req_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL prio_grant: got lsu/ifu ready=%b expected 10",
                     {bus.lsu_req_ready, bus.ifu_req_ready});
        end
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask, bus.ifu_req_ready} !==
            {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 1'b0}) begin
            errors++;
            $display("[TB] FAIL prio_store_req: got a=%h w=%b d=%h m=%h ifu_rdy=%b expected 80001000 1 deadbeef 0f 0",
                     bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask, bus.ifu_req_ready);
        end
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({bus.lsu_resp_valid, bus.lsu_resp_data, bus.lsu_resp_err, bus.ifu_resp_valid} !==
            {1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL store_resp: got v=%b d=%h e=%b ifu_rv=%b expected 1 00000000 0 0",
                     bus.lsu_resp_valid, bus.lsu_resp_data, bus.lsu_resp_err, bus.ifu_resp_valid);
        end
        tick();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL ifu_after_lsu: got ifu/lsu ready=%b expected 10",
                     {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask} !==
            {1'b1, 32'h8000_0004, 1'b0, 8'h00}) begin
            errors++;
            $display("[TB] FAIL fetch_req: got v=%b a=%h w=%b m=%h expected 1 80000004 0 00",
                     bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask);
        end
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h0000_0013;
        @(negedge clk);
        checks++;
        if ({bus.ifu_resp_valid, bus.ifu_resp_data, bus.ifu_resp_err, bus.lsu_resp_valid} !==
            {1'b1, 32'h0000_0013, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL fetch_resp: got v=%b d=%h e=%b lsu_rv=%b expected 1 00000013 0 0",
                     bus.ifu_resp_valid, bus.ifu_resp_data, bus.ifu_resp_err, bus.lsu_resp_valid);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall();
        do_txn(1'b0, 1'b1, 32'h0, 32'h8000_2000, 1'b1, 32'hA5A5_5A5A, 8'h3C,
               5, 1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_timeout();
        do_txn(1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0, 32'h0, 8'h00,
               0, 20, 1'b1, 1'b0, 32'h0);
        do_txn(1'b0, 1'b1, 32'h0, 32'h8000_0080, 1'b0, 32'h0, 8'hFF,
               2, TO, 1'b1, 1'b0, 32'h0);
        do_txn(1'b1, 1'b1, 32'h8000_0100, 32'h8000_0104, 1'b0, 32'h0, 8'h0F,
               0, TO - 1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        int mode;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            do_txn(mode != 1, mode != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   $urandom, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 6),
                   1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_ifu_basic();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
